// File: rtl/lsu_pkg.sv
// lsu_pkg: shared op-field positions, size codes and FSM states for the load/store unit
package lsu_pkg;
    localparam int OP_ST = 3;
    localparam int OP_UNS = 2;
    localparam int OP_SZ_HI = 1;
    localparam int OP_SZ_LO = 0;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: little-endian lane extraction with sign/zero extension, and sub-word store merge
// size/uns/off select the lane; rdata is the memory word, wdata the store data;
// ldata is the extended load value, mdata the word to write back.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] mdata
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = rdata[8*off +: 8];
        h = rdata[16*off[1] +: 16];
        ldata = size == SZ_B ? {{24{b[7] & ~uns}}, b}
              : size == SZ_H ? {{16{h[15] & ~uns}}, h} : rdata;
        mdata = rdata;
        if (size == SZ_B) mdata[8*off +: 8] = wdata[7:0];
        else if (size == SZ_H) mdata[16*off[1] +: 16] = wdata[15:0];
        else mdata = wdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding byte/half/word load/store initiator for a word-wide data memory
// req_*: request handshake and payload; rsp_*: one-cycle response;
// mem_*: word address, write data, write strobe and combinational read data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata
);
    state_t      state, nxt;
    logic [3:0]  op_q;
    logic [31:0] addr_q, wdata_q, rdata_q, ldata, mdata;
    logic        err_q, err;
    logic [1:0]  sz;
    assign sz = req_op[OP_SZ_HI:OP_SZ_LO];
    assign err = sz == 2'b11 || (sz == SZ_H && req_addr[0]) ||
                 (sz == SZ_W && req_addr[1:0] != 2'b00) || req_addr >= 32'(MEM_WORDS * 4);
    lsu_lane u_lane (
        .size  (op_q[OP_SZ_HI:OP_SZ_LO]),
        .uns   (op_q[OP_UNS]),
        .off   (addr_q[1:0]),
        .rdata (mem_rdata),
        .wdata (wdata_q),
        .ldata (ldata),
        .mdata (mdata)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && req_valid) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= err;
                rdata_q <= '0;
            end
            // RD feeds either the response register (load) or the write-back word (sub-word store)
            if (state == RD) begin
                if (op_q[OP_ST]) wdata_q <= mdata;
                else rdata_q <= ldata;
            end
        end
    end
    always_comb begin
        nxt = state == IDLE ? (!req_valid ? IDLE : err ? RESP
                              : (req_op[OP_ST] && sz == SZ_W) ? WR : RD)
            : state == RD ? (op_q[OP_ST] ? WR : RESP)
            : state == WR ? RESP : IDLE;
        req_ready = state == IDLE;
        rsp_valid = state == RESP;
        rsp_rdata = state == RESP ? rdata_q : '0;
        rsp_err   = state == RESP && err_q;
        mem_addr  = (state == RD || state == WR) ? {addr_q[31:2], 2'b00} : '0;
        mem_wdata = state == WR ? wdata_q : '0;
        mem_wr    = state == WR;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed-vector self-checking bench with a word-wide memory model
module tb_load_store_unit;
    logic        clk = 0, rst = 1, req_valid = 0, req_ready, rsp_valid, rsp_err, mem_wr;
    logic [3:0]  req_op = '0;
    logic [31:0] req_addr = '0, req_wdata = '0, rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [0:255];
    int          total = 0, bad = 0;
    int          lat, wn, wk;
    logic [31:0] rd, wa, wdat;
    logic        er;

    localparam logic [3:0] LB = 4'b0000, LH = 4'b0001, LW = 4'b0010, LBU = 4'b0100,
                           LHU = 4'b0101, SB = 4'b1000, SH = 4'b1001, SW = 4'b1010, BADSZ = 4'b0011;

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;

    task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // issue one request at a negedge and follow it until its response (bounded)
    task run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
        lat = 0; wn = 0; wk = 0; rd = 'x; er = 1'bx; wa = '0; wdat = '0;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        req_op = op; req_addr = a; req_wdata = d; req_valid = 1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            if (mem_wr) begin wn++; wk = k; wa = mem_addr; wdat = mem_wdata; end
            if (rsp_valid) begin lat = k; rd = rsp_rdata; er = rsp_err; end
            else @(negedge clk);
        end
    endtask

    task ld(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] exp);
        run(op, a, 32'h0);
        chk({tag, " lat"}, 32'(lat), 32'd2);
        chk({tag, " data"}, rd, exp);
    endtask

    task error_case(input string tag, input logic [3:0] op, input logic [31:0] a);
        run(op, a, 32'h5555_5555);
        chk({tag, " lat"}, 32'(lat), 32'd1);
        chk({tag, " err"}, 32'(er), 32'd1);
        chk({tag, " rdata"}, rd, 32'h0);
        chk({tag, " writes"}, 32'(wn), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst ready", 32'(req_ready), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst mem_wr", 32'(mem_wr), 32'd0);
        @(negedge clk);
        rst = 0;

        run(SW, 32'h10, 32'hDEADBEEF);
        chk("sw lat", 32'(lat), 32'd2);
        chk("sw writes", 32'(wn), 32'd1);
        chk("sw wr cycle", 32'(wk), 32'd1);
        chk("sw waddr", wa, 32'h10);
        chk("sw wdata", wdat, 32'hDEADBEEF);
        chk("sw rdata", rd, 32'h0);
        chk("sw err", 32'(er), 32'd0);
        ld("lw 10", LW, 32'h10, 32'hDEADBEEF);

        run(SW, 32'h10, 32'h11223344);
        run(SB, 32'h11, 32'h000000AA);
        chk("sb lat", 32'(lat), 32'd3);
        chk("sb writes", 32'(wn), 32'd1);
        chk("sb wr cycle", 32'(wk), 32'd2);
        chk("sb waddr", wa, 32'h10);
        chk("sb wdata", wdat, 32'h1122AA44);
        ld("lw after sb", LW, 32'h10, 32'h1122AA44);
        run(SH, 32'h12, 32'hFFFF_BEEF);
        chk("sh wdata", wdat, 32'hBEEFAA44);

        run(SW, 32'h20, 32'h8000FF7F);
        ld("lb 20", LB, 32'h20, 32'h0000007F);
        ld("lb 21", LB, 32'h21, 32'hFFFFFFFF);
        ld("lbu 21", LBU, 32'h21, 32'h000000FF);
        ld("lh 22", LH, 32'h22, 32'hFFFF8000);
        ld("lhu 22", LHU, 32'h22, 32'h00008000);
        ld("lh 20", LH, 32'h20, 32'hFFFFFF7F);

        error_case("lw 13", LW, 32'h13);
        error_case("sh 15", SH, 32'h15);
        error_case("sw 400", SW, 32'h400);
        error_case("size 11", BADSZ, 32'h0);

        // back-pressure: second request held on the bus during a load
        @(negedge clk);
        req_op = LW; req_addr = 32'h20; req_valid = 1;
        @(posedge clk);
        @(negedge clk);
        req_op = LB; req_addr = 32'h21;
        chk("bp ready t1", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("bp ready t2", 32'(req_ready), 32'd0);
        chk("bp first rsp", rsp_rdata, 32'h8000FF7F);
        @(negedge clk);
        chk("bp ready t3", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("bp accepted t3", 32'(req_ready), 32'd0);
        req_valid = 0;
        @(negedge clk);
        chk("bp second valid", 32'(rsp_valid), 32'd1);
        chk("bp second rsp", rsp_rdata, 32'hFFFFFFFF);

        // reset during the WR cycle of a store
        run(SW, 32'h30, 32'h12345678);
        @(negedge clk);
        req_op = SW; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_valid = 1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        chk("rst wr before", 32'(mem_wr), 32'd1);
        #2 rst = 1;
        #1;
        chk("rst wr dropped", 32'(mem_wr), 32'd0);
        chk("rst mem_addr mid", mem_addr, 32'h0);
        chk("rst ready mid", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 0;
        chk("rst word kept", mem[12], 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            chk("rst no rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        chk("rst ready after", 32'(req_ready), 32'd1);
        ld("lw 30", LW, 32'h30, 32'h12345678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
